// File: rtl/emu_ckpt_pkg.sv
// Shared types and constants for the checkpoint sequencer (state encoding, CRC-32 constants, scan word width).
package emu_ckpt_pkg;

   localparam int          SCAN_W   = 64;
   localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {S_IDLE, S_DOWN, S_FF, S_RAM, S_UP} ckpt_state_e;

   // MSB-first, unreflected CRC-32 update over one scan word.
   function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [SCAN_W-1:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = SCAN_W - 1; i >= 0; i--)
         c = (c[31] ^ data[i]) ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
      return c;
   endfunction

endpackage

// File: rtl/emu_ckpt_ctrl_if.sv
// Host command/stream and emulator scan/handshake signals of the checkpoint sequencer.
interface emu_ckpt_ctrl_if;
   import emu_ckpt_pkg::*;

   logic              cmd_valid, cmd_ready, cmd_load;
   logic              busy, done;
   logic [31:0]       crc;
   logic              pause, down_req, down, up_req, up;
   logic              ff_scan, ff_dir;
   logic [SCAN_W-1:0] ff_sdi, ff_sdo;
   logic              ram_scan, ram_dir;
   logic [SCAN_W-1:0] ram_sdi, ram_sdo;
   logic              sv_valid, sv_ready;
   logic [SCAN_W-1:0] sv_data;
   logic              ld_valid, ld_ready;
   logic [SCAN_W-1:0] ld_data;

   modport master (
      input  cmd_valid, cmd_load, down, up, ff_sdo, ram_sdo, sv_ready, ld_valid, ld_data,
      output cmd_ready, busy, done, crc, pause, down_req, up_req,
             ff_scan, ff_dir, ff_sdi, ram_scan, ram_dir, ram_sdi, sv_valid, sv_data, ld_ready
   );

   modport slave (
      output cmd_valid, cmd_load, down, up, ff_sdo, ram_sdo, sv_ready, ld_valid, ld_data,
      input  cmd_ready, busy, done, crc, pause, down_req, up_req,
             ff_scan, ff_dir, ff_sdi, ram_scan, ram_dir, ram_sdi, sv_valid, sv_data, ld_ready
   );

endinterface

// File: rtl/emu_ckpt_skid.sv
// Two-entry valid/ready FIFO with occupancy output; absorbs the one-cycle RAM read latency on save.
module emu_ckpt_skid #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic [1:0]   occ
);

   logic [W-1:0] q0, q1;
   logic [1:0]   cnt;
   logic         push, pop;

   assign out_valid = (cnt != 2'd0);
   assign out_data  = q0;
   assign occ       = cnt;
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && ((cnt != 2'd2) || out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 2'd0;
         q0  <= '0;
         q1  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) q0 <= in_data;
               else             q1 <= in_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               q0  <= q1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) q0 <= in_data;
               else begin
                  q0 <= q1;
                  q1 <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/emu_ckpt_ctrl.sv
// Checkpoint sequencer: quiesce the model, stream FF then RAM scan words to/from the host, resume.
// Define EMU_CKPT_CRC_EN to build a CRC-32 over every transferred word; otherwise crc is 0.
module emu_ckpt_ctrl
   import emu_ckpt_pkg::*;
#(
   parameter int FF_WORDS  = 16,
   parameter int RAM_WORDS = 64,
   parameter int CNT_WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   emu_ckpt_ctrl_if.master bus
);

   ckpt_state_e          state_q, state_d;
   logic                 load_q, inflight, done_q, accept;
   logic [CNT_WIDTH-1:0] ff_cnt, ram_cnt;
   logic [CNT_WIDTH:0]   ram_iss;
   logic                 ff_last, ram_last, iss_done;
   logic                 sk_valid, sk_rdy, sk_pop;
   logic [SCAN_W-1:0]    sk_data;
   logic [1:0]           sk_occ;

   assign accept   = (state_q == S_IDLE) && bus.cmd_valid;
   assign ff_last  = (ff_cnt == CNT_WIDTH'(FF_WORDS - 1));
   assign ram_last = (ram_cnt == CNT_WIDTH'(RAM_WORDS - 1));
   assign iss_done = (ram_iss == (CNT_WIDTH + 1)'(RAM_WORDS));
   assign sk_rdy   = bus.sv_ready && (state_q == S_RAM) && !load_q;
   assign sk_pop   = sk_valid && sk_rdy;
   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;

   emu_ckpt_skid #(.W(SCAN_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight),
      .in_data   (bus.ram_sdo),
      .out_valid (sk_valid),
      .out_data  (sk_data),
      .out_ready (sk_rdy),
      .occ       (sk_occ)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         load_q   <= 1'b0;
         inflight <= 1'b0;
         done_q   <= 1'b0;
         ff_cnt   <= '0;
         ram_cnt  <= '0;
         ram_iss  <= '0;
      end else begin
         state_q  <= state_d;
         done_q   <= (state_q == S_UP) && bus.up;
         inflight <= bus.ram_scan && !load_q;
         if (accept) begin
            load_q  <= bus.cmd_load;
            ff_cnt  <= '0;
            ram_cnt <= '0;
            ram_iss <= '0;
         end else begin
            if (bus.ff_scan)                        ff_cnt  <= ff_cnt + CNT_WIDTH'(1);
            if ((load_q && bus.ram_scan) || sk_pop) ram_cnt <= ram_cnt + CNT_WIDTH'(1);
            if (bus.ram_scan)                       ram_iss <= ram_iss + (CNT_WIDTH + 1)'(1);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.cmd_ready = 1'b0;
      bus.pause     = 1'b0;
      bus.down_req  = 1'b0;
      bus.up_req    = 1'b0;
      bus.ff_scan   = 1'b0;
      bus.ff_dir    = 1'b0;
      bus.ff_sdi    = '0;
      bus.ram_scan  = 1'b0;
      bus.ram_dir   = 1'b0;
      bus.ram_sdi   = '0;
      bus.sv_valid  = 1'b0;
      bus.sv_data   = '0;
      bus.ld_ready  = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) state_d = S_DOWN;
         end
         S_DOWN: begin
            bus.pause    = 1'b1;
            bus.down_req = 1'b1;
            if (bus.down) state_d = S_FF;
         end
         S_FF: begin
            bus.pause  = 1'b1;
            bus.ff_dir = load_q;
            if (load_q) begin
               bus.ld_ready = 1'b1;
               bus.ff_sdi   = bus.ld_data;
               bus.ff_scan  = bus.ld_valid;
            end else begin
               // dir=0 recirculates the chain, so a save leaves model state intact
               bus.sv_valid = 1'b1;
               bus.sv_data  = bus.ff_sdo;
               bus.ff_scan  = bus.sv_ready;
            end
            if (bus.ff_scan && ff_last) state_d = S_RAM;
         end
         S_RAM: begin
            bus.pause   = 1'b1;
            bus.ram_dir = load_q;
            if (load_q) begin
               bus.ld_ready = 1'b1;
               bus.ram_sdi  = bus.ld_data;
               bus.ram_scan = bus.ld_valid;
               if (bus.ld_valid && ram_last) state_d = S_UP;
            end else begin
               // a word popped this cycle frees its slot, which keeps reads at one per cycle
               bus.sv_valid = sk_valid;
               bus.sv_data  = sk_data;
               bus.ram_scan = !iss_done &&
                              (({1'b0, sk_occ} + {2'b0, inflight}) < (3'd2 + {2'b0, sk_pop}));
               if (sk_pop && ram_last) state_d = S_UP;
            end
         end
         S_UP: begin
            bus.pause  = 1'b1;
            bus.up_req = 1'b1;
            if (bus.up) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef EMU_CKPT_CRC_EN
   logic              xfer_vld;
   logic [SCAN_W-1:0] xfer_data;
   logic [31:0]       crc_q;

   assign xfer_vld  = bus.ff_scan || (load_q && bus.ram_scan) || sk_pop;
   assign xfer_data = load_q ? bus.ld_data : bus.sv_data;
   assign bus.crc   = ~crc_q;

   always_ff @(posedge clk) begin
      if (rst || accept) crc_q <= CRC_INIT;
      else if (xfer_vld) crc_q <= crc32_word(crc_q, xfer_data);
   end
`else
   assign bus.crc = '0;
`endif

endmodule

// File: tb/tb_emu_ckpt_ctrl.sv
// Directed bench for emu_ckpt_ctrl: models the FF/RAM chains and down/up responders, checks saves, loads and reset.
module tb_emu_ckpt_ctrl;

   localparam int FFW = 4, RAMW = 8, NW = FFW + RAMW;
   localparam logic [63:0] FFPAT  = 64'hA5A5_0000_0000_0000;
   localparam logic [63:0] RAMPAT = 64'h5A5A_0000_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   emu_ckpt_ctrl_if bus();

   emu_ckpt_ctrl #(.FF_WORDS(FFW), .RAM_WORDS(RAMW), .CNT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---- environment model: scan chains, down/up responders ----
   logic [63:0] ff_chain  [FFW];
   logic [63:0] ram_chain [RAMW];
   logic [63:0] ram_sdo_q;
   logic [1:0]  dn_d = '0;
   logic        up_d = 1'b0;
   logic        preset_go = 1'b0;
   int          preset_sel = 0;

   assign bus.ff_sdo  = ff_chain[0];
   assign bus.ram_sdo = ram_sdo_q;
   assign bus.down    = dn_d[1];
   assign bus.up      = up_d;

   always @(posedge clk) begin
      if (preset_go) begin
         for (int i = 0; i < FFW; i++)  ff_chain[i]  <= (preset_sel == 0) ? FFPAT + 64'(i) : 64'h0;
         for (int i = 0; i < RAMW; i++) ram_chain[i] <= (preset_sel == 0) ? RAMPAT + 64'(i) : 64'h0;
         ram_sdo_q <= '0;
      end else begin
         if (bus.ff_scan) begin
            for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i+1];
            ff_chain[FFW-1] <= bus.ff_dir ? bus.ff_sdi : ff_chain[0];
         end
         if (bus.ram_scan) begin
            ram_sdo_q <= ram_chain[0];
            for (int i = 0; i < RAMW - 1; i++) ram_chain[i] <= ram_chain[i+1];
            ram_chain[RAMW-1] <= bus.ram_dir ? bus.ram_sdi : ram_chain[0];
         end
      end
      dn_d <= {dn_d[0], bus.down_req};
      up_d <= bus.up_req;
   end

   // ---- monitor ----
   logic [63:0] sv_q[$];
   int n_done = 0, n_ffs = 0, n_rams = 0, n_both = 0, n_busy_rise = 0, n_rdy_busy = 0, n_stab = 0;
   logic pause_at_done = 1'b1, prev_busy = 1'b0, prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
   logic [31:0] crc_at_done = '0;
   logic [63:0] prev_d = '0;

   always @(negedge clk) begin
      if (bus.sv_valid && bus.sv_ready) sv_q.push_back(bus.sv_data);
      if (bus.ff_scan) n_ffs++;
      if (bus.ram_scan) n_rams++;
      if (bus.ff_scan && bus.ram_scan) n_both++;
      if (bus.busy && !prev_busy) n_busy_rise++;
      if (bus.busy && bus.cmd_ready) n_rdy_busy++;
      if (!rst && !prev_rst && prev_v && !prev_r && (!bus.sv_valid || bus.sv_data !== prev_d)) n_stab++;
      if (bus.done) begin
         n_done++;
         pause_at_done = bus.pause;
         crc_at_done   = bus.crc;
      end
      prev_busy = bus.busy;
      prev_v    = bus.sv_valid;
      prev_r    = bus.sv_ready;
      prev_d    = bus.sv_data;
      prev_rst  = rst;
   end

   logic [11:0] ctl;
   assign ctl = {bus.cmd_ready, bus.busy, bus.done, bus.pause, bus.down_req, bus.up_req,
                 bus.ff_scan, bus.ff_dir, bus.ram_scan, bus.ram_dir, bus.sv_valid, bus.ld_ready};

   // ---- checking ----
   int n_vec = 0, n_err = 0;
   logic [63:0] exp_w [NW];
   int b_words, b_done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

`ifdef EMU_CKPT_CRC_EN
   function automatic logic [31:0] crc_ref();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < NW; k++)
         for (int b = 7; b >= 0; b--) begin
            c = c ^ {exp_w[k][b*8 +: 8], 24'h0};
            for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
         end
      return ~c;
   endfunction
`endif

   task automatic chk_rst_outs(input string tag);
      chk({tag, "_ctl"}, 64'(ctl), 64'h800);
      chk({tag, "_data"}, bus.ff_sdi | bus.ram_sdi | bus.sv_data, 64'h0);
      chk({tag, "_crc"}, 64'(bus.crc), 64'h0);
   endtask

   task automatic run(input string tag, input logic load, input bit toggle, input bit gaps,
                      input bit hold, input bit abort);
      int  li;
      bit  fin;
      b_words = sv_q.size();
      b_done  = n_done;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = load;
      bus.sv_ready  = 1'b0;
      @(negedge clk);
      chk({tag, "_rdy"}, 64'(bus.cmd_ready), 64'h1);
      @(posedge clk); #1;
      if (!hold) bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat"}, 64'({bus.pause, bus.down_req, bus.busy, bus.cmd_ready}), 64'hE);
      li  = 0;
      fin = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(posedge clk); #1;
         bus.sv_ready = !toggle || (c % 2 == 1);
         bus.ld_valid = load && (li < NW) && !(gaps && (c % 3 == 1));
         bus.ld_data  = 64'h1000 + 64'(li);
         @(negedge clk);
         if (bus.ld_valid && bus.ld_ready) li++;
         if (bus.done) begin
            fin = 1'b1;
            bus.cmd_valid = 1'b0;
         end
         if (abort && bus.ram_scan) begin
            @(posedge clk); #1;
            rst = 1'b1;
            bus.sv_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk_rst_outs({tag, "_rst"});
            return;
         end
      end
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      bus.sv_ready = 1'b0;
      chk({tag, "_done"}, 64'(fin), 64'h1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_save(input string tag);
      logic [63:0] g;
      chk({tag, "_nw"}, 64'(sv_q.size() - b_words), 64'(NW));
      for (int i = 0; i < NW; i++) begin
         g = (b_words + i < sv_q.size()) ? sv_q[b_words + i] : 'x;
         chk($sformatf("%s_w%0d", tag, i), g, exp_w[i]);
      end
      chk({tag, "_ndone"}, 64'(n_done - b_done), 64'h1);
      chk({tag, "_pause"}, 64'(pause_at_done), 64'h0);
`ifdef EMU_CKPT_CRC_EN
      chk({tag, "_crc"}, 64'(crc_at_done), 64'(crc_ref()));
`else
      chk({tag, "_crc"}, 64'(crc_at_done), 64'h0);
`endif
   endtask

   task automatic preset(input int sel);
      @(posedge clk); #1;
      preset_sel = sel;
      preset_go  = 1'b1;
      @(posedge clk); #1;
      preset_go  = 1'b0;
   endtask

   initial begin
      int s_ff, s_ram, s_busy;
      bus.cmd_valid = 1'b0;
      bus.cmd_load  = 1'b0;
      bus.sv_ready  = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.ld_data   = '1;
      preset(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_rst_outs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      bus.ld_data = '0;

      // plain save, sv_ready held
      for (int i = 0; i < NW; i++) exp_w[i] = (i < FFW) ? FFPAT + 64'(i) : RAMPAT + 64'(i - FFW);
      run("t1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_save("t1");

      // save with sv_ready toggling; chains were recirculated so contents are unchanged
      s_ff  = n_ffs;
      s_ram = n_rams;
      run("t2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_save("t2");
      chk("t2_ffscan", 64'(n_ffs - s_ff), 64'(FFW));
      chk("t2_ramscan", 64'(n_rams - s_ram), 64'(RAMW));
      chk("t2_stable", 64'(n_stab), 64'h0);

      // load 0x1000+i with gaps, then save back with cmd_valid held through busy
      run("t3l", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < NW; i++) exp_w[i] = 64'h1000 + 64'(i);
      s_busy = n_busy_rise;
      run("t3s", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_save("t3s");
      chk("t3_accepts", 64'(n_busy_rise - s_busy), 64'h1);

      // reset in RAM state, then a fresh save of whatever the chains now hold
      run("t4a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < NW; i++) exp_w[i] = (i < FFW) ? ff_chain[i] : ram_chain[i - FFW];
      run("t4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_save("t4");

      // all-zero checkpoint
      preset(1);
      for (int i = 0; i < NW; i++) exp_w[i] = 64'h0;
      run("t5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_save("t5");

      chk("both_scan", 64'(n_both), 64'h0);
      chk("rdy_busy", 64'(n_rdy_busy), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
